param_cmd_queue: RTL and testbench

PARAM_CMD_QUEUE -- requirements
Module: param_cmd_queue

---
 rtl/param_bus_pkg.sv | 47 ++++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/param_cmd_queue.sv | 154 +++++++++++++++
 tb/tb_param_cmd_queue.sv | 540 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_bus_pkg.sv
// Register map, status layout and stall timing shared by the
// parameter command queue and its FIFO.
package param_bus_pkg;

    localparam logic [3:0] OFF_ID     = 4'h0;
    localparam logic [3:0] OFF_VALUE  = 4'h4;
    localparam logic [3:0] OFF_STATUS = 4'h8;
    localparam logic [3:0] OFF_CTRL   = 4'hC;

    localparam int STS_FULL    = 0;
    localparam int STS_EMPTY   = 1;
    localparam int STS_OVF     = 2;
    localparam int STS_DONE    = 3;
    localparam int STS_CNT_LSB = 8;

    localparam int STALL_TIMEOUT = 1024;
    localparam int STALL_W       = $clog2(STALL_TIMEOUT);

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] value;
    } cmd_t;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_ACK,
        BUS_STALL
    } bus_state_t;

    function automatic logic [31:0] status_word(
        input logic [7:0] cnt,
        input logic       done,
        input logic       ovf,
        input logic       empty,
        input logic       full
    );
        logic [31:0] w;
        w = '0;
        w[STS_CNT_LSB +: 8] = cnt;
        w[STS_DONE]         = done;
        w[STS_OVF]          = ovf;
        w[STS_EMPTY]        = empty;
        w[STS_FULL]         = full;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; flush beats push and pop,
// and a push into a full FIFO is allowed when a pop frees the slot.
module sync_fifo
    import param_bus_pkg::*;
#(
    parameter int WIDTH = $bits(cmd_t),
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW + 1)'(do_push)
                           - (AW + 1)'(do_pop);
        end
    end

endmodule

// File: rtl/param_cmd_queue.sv
// picorv32-bus register window that queues {id, value} parameter
// commands for a downstream consumer, with drain-done interrupt.
module param_cmd_queue
    import param_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_8100,
    parameter int          DEPTH     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        sel,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_id,
    output logic [31:0] out_value,
    output logic        irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    bus_state_t         state;
    logic [STALL_W-1:0] stall_cnt;
    logic [7:0]         id_reg;
    logic               irq_en;
    logic               done;
    logic               overflow;

    logic [31:0]   offs;
    logic          in_win;
    logic          start;
    logic          is_id, is_val, is_sts, is_ctl;
    logic          val_wr, sts_rd;
    logic          pop, push, flush;
    logic          abort, done_set;
    logic          full, empty;
    logic [CW-1:0] count;
    logic [7:0]    count8;
    cmd_t          wcmd, head;
    logic [31:0]   rd_mux;

    // Unsigned wrap makes addresses below the base fall outside too.
    assign offs   = mem_addr - BASE_ADDR;
    assign in_win = (offs < 32'd16);
    assign sel    = mem_valid && in_win;
    assign start  = sel && (state == BUS_IDLE);

    assign is_id  = (offs[3:2] == OFF_ID[3:2]);
    assign is_val = (offs[3:2] == OFF_VALUE[3:2]);
    assign is_sts = (offs[3:2] == OFF_STATUS[3:2]);
    assign is_ctl = (offs[3:2] == OFF_CTRL[3:2]);

    assign val_wr = start && is_val && (mem_wstrb == 4'hF);
    assign sts_rd = start && is_sts && (mem_wstrb == 4'h0);
    assign flush  = start && is_ctl && mem_wstrb[0]
                    && mem_wdata[1];

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign push      = (val_wr && (!full || pop))
                       || ((state == BUS_STALL) && pop);

    assign abort = (state == BUS_STALL) && !pop
                   && (stall_cnt == STALL_W'(STALL_TIMEOUT - 1));
    assign done_set = pop && (count == CW'(1))
                      && !push && !flush;

    assign wcmd      = {id_reg, mem_wdata};
    assign out_id    = head.id;
    assign out_value = head.value;
    assign count8    = 8'(count);

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            is_id:   rd_mux = {24'h0, id_reg};
            is_sts:  rd_mux = status_word(count8, done,
                                          overflow, empty, full);
            is_ctl:  rd_mux = {31'h0, irq_en};
            default: rd_mux = '0;
        endcase
    end

    sync_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wcmd),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BUS_IDLE;
            stall_cnt <= '0;
            id_reg    <= '0;
            irq_en    <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            irq       <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            irq       <= irq_en && done;
            done      <= done_set || (done && !sts_rd);
            overflow  <= abort || (overflow && !sts_rd);
            unique case (state)
                BUS_IDLE: begin
                    if (start) begin
                        if (val_wr && full && !pop) begin
                            state     <= BUS_STALL;
                            stall_cnt <= '0;
                        end else begin
                            state     <= BUS_ACK;
                            mem_ready <= 1'b1;
                            if (mem_wstrb == 4'h0)
                                mem_rdata <= rd_mux;
                        end
                        if (is_id && mem_wstrb[0])
                            id_reg <= mem_wdata[7:0];
                        if (is_ctl && mem_wstrb[0])
                            irq_en <= mem_wdata[0];
                    end
                end
                BUS_ACK: state <= BUS_IDLE;
                BUS_STALL: begin
                    if (pop || abort) begin
                        state     <= BUS_ACK;
                        mem_ready <= 1'b1;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                default: state <= BUS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_param_cmd_queue.sv
// Scenario bench for param_cmd_queue: directed cases plus a
// randomized push/pop run against a queue-based reference model.
module tb_param_cmd_queue;

    localparam logic [31:0] BASE  = 32'h0000_8100;
    localparam int          DEPTH = 8;
    localparam logic [31:0] A_ID  = BASE + 32'h0;
    localparam logic [31:0] A_VAL = BASE + 32'h4;
    localparam logic [31:0] A_STS = BASE + 32'h8;
    localparam logic [31:0] A_CTL = BASE + 32'hC;

    logic        clk_50M;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        sel;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_id;
    logic [31:0] out_value;
    logic        irq;

    param_cmd_queue #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk_50M),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .sel       (sel),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_value (out_value),
        .irq       (irq)
    );

    typedef struct {
        int          cyc;
        logic [7:0]  id;
        logic [31:0] val;
    } pop_t;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    pop_t        popped[$];
    logic [39:0] exp_q[$];
    logic [7:0]  model_id;

    logic [31:0] rdv;
    int          lat;
    int          rc;
    logic        aft;
    logic        irr;

    initial clk_50M = 1'b0;
    always #10 clk_50M = ~clk_50M;

    always @(posedge clk_50M) begin
        cyc = cyc + 1;
        if (!rst && out_valid && out_ready)
            popped.push_back('{cyc, out_id, out_value});
    end

    function automatic logic [31:0] exp_status(
        input int cnt, input bit d, input bit o);
        return 32'(cnt * 256 + (d ? 8 : 0) + (o ? 4 : 0)
                   + (cnt == 0 ? 2 : 0)
                   + (cnt == DEPTH ? 1 : 0));
    endfunction

    task automatic bus(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int maxc);
        rdv = 0; lat = -1; rc = -1; aft = 0; irr = 0;
        @(negedge clk_50M);
        mem_valid = 1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
        for (int i = 1; i <= maxc; i++) begin
            @(posedge clk_50M); #1;
            if (mem_ready) begin
                lat = i; rdv = mem_rdata; rc = cyc; irr = irq;
                break;
            end
        end
        @(negedge clk_50M);
        mem_valid = 0; mem_wstrb = 0;
        @(posedge clk_50M); #1;
        aft = mem_ready;
    endtask

    task automatic fill(input int n);
        logic [31:0] v;
        for (int i = 0; i < n; i++) begin
            v = $urandom;
            bus(A_VAL, v, 4'hF, 20);
            exp_q.push_back({model_id, v});
            n_chk++;
            if (lat !== 1) begin
                n_fail++;
                $display("FAIL fill_lat[%0d] got %0d want 1", i, lat);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1; repeat (3) @(posedge clk_50M); #1;
        n_chk++;
        if ({mem_ready, out_valid, irq, sel} !== 4'b0) begin
            n_fail++;
            $display("FAIL rst_outs got %b want 0000",
                     {mem_ready, out_valid, irq, sel});
        end
        n_chk++;
        if (mem_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_rdata got %h want 0", mem_rdata);
        end
        @(negedge clk_50M); rst = 0;
        model_id = 8'h00;
        bus(A_STS, 0, 4'h0, 20);
        n_chk++;
        if (rdv !== 32'h2 || lat !== 1 || aft !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_status got %h/%0d/%b want 2/1/0",
                     rdv, lat, aft);
        end
        bus(A_ID, 0, 4'h0, 20);
        n_chk++;
        if (rdv !== 32'h0) begin
            n_fail++; $display("FAIL rst_id got %h want 0", rdv);
        end
        bus(A_CTL, 0, 4'h0, 20);
        n_chk++;
        if (rdv !== 32'h0) begin
            n_fail++; $display("FAIL rst_ctrl got %h want 0", rdv);
        end
    endtask

    task automatic test_basic;
        pop_t p;
        int   wrc;
        out_ready = 1; popped.delete();
        bus(A_ID, 32'hAB12, 4'hF, 20);
        model_id = 8'h12;
        bus(A_ID, 0, 4'h0, 20);
        n_chk++;
        if (rdv !== 32'h12) begin
            n_fail++; $display("FAIL id_read got %h want 12", rdv);
        end
        bus(A_VAL, 32'hDEADBEEF, 4'hF, 20);
        wrc = rc;
        n_chk++;
        if (lat !== 1) begin
            n_fail++; $display("FAIL push_lat got %0d want 1", lat);
        end
        repeat (2) @(posedge clk_50M); #1;
        n_chk++;
        if (popped.size() !== 1) begin
            n_fail++;
            $display("FAIL basic_pops got %0d want 1", popped.size());
        end
        p = (popped.size() > 0) ? popped.pop_front()
                                : '{-1, 8'h0, 32'h0};
        n_chk++;
        if (p.id !== 8'h12 || p.val !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL basic_head got %h/%h want 12/deadbeef",
                     p.id, p.val);
        end
        n_chk++;
        if (p.cyc !== wrc + 1) begin
            n_fail++;
            $display("FAIL basic_pop_cyc got %0d want %0d",
                     p.cyc, wrc + 1);
        end
        out_ready = 0;
        bus(A_STS, 0, 4'h0, 20);
        n_chk++;
        if (rdv !== exp_status(0, 1, 0)) begin
            n_fail++;
            $display("FAIL basic_done got %h want %h",
                     rdv, exp_status(0, 1, 0));
        end
        bus(A_STS, 0, 4'h0, 20);
        n_chk++;
        if (rdv !== exp_status(0, 0, 0)) begin
            n_fail++;
            $display("FAIL done_clear got %h want %h",
                     rdv, exp_status(0, 0, 0));
        end
    endtask

    task automatic test_back_to_back;
        pop_t        p;
        logic [39:0] e;
        logic [31:0] v9;
        int          nm;
        out_ready = 0; popped.delete(); exp_q.delete();
        fill(DEPTH);
        v9 = $urandom;
        fork
            bus(A_VAL, v9, 4'hF, 100);
            begin
                repeat (20) @(negedge clk_50M);
                out_ready = 1;
                @(negedge clk_50M);
                out_ready = 0;
            end
        join
        exp_q.push_back({model_id, v9});
        n_chk++;
        if (lat !== 20) begin
            n_fail++; $display("FAIL stall_lat got %0d want 20", lat);
        end
        p = (popped.size() > 0) ? popped.pop_front()
                                : '{-1, 8'h0, 32'h0};
        e = exp_q.pop_front();
        n_chk++;
        if (p.cyc !== rc || {p.id, p.val} !== e) begin
            n_fail++;
            $display("FAIL stall_pop got %0d:%h want %0d:%h",
                     p.cyc, {p.id, p.val}, rc, e);
        end
        bus(A_STS, 0, 4'h0, 20);
        n_chk++;
        if (rdv !== exp_status(DEPTH, 0, 0)) begin
            n_fail++;
            $display("FAIL stall_count got %h want %h",
                     rdv, exp_status(DEPTH, 0, 0));
        end
        out_ready = 1;
        repeat (DEPTH + 4) @(posedge clk_50M); #1;
        out_ready = 0;
        n_chk++;
        if (popped.size() !== DEPTH) begin
            n_fail++;
            $display("FAIL drain_pops got %0d want %0d",
                     popped.size(), DEPTH);
        end
        nm = 0;
        while (popped.size() > 0 && exp_q.size() > 0) begin
            p = popped.pop_front(); e = exp_q.pop_front();
            if ({p.id, p.val} !== e) nm++;
        end
        n_chk++;
        if (nm !== 0) begin
            n_fail++; $display("FAIL drain_order got %0d bad want 0", nm);
        end
        bus(A_STS, 0, 4'h0, 20);
        n_chk++;
        if (rdv !== exp_status(0, 1, 0)) begin
            n_fail++;
            $display("FAIL drain_done got %h want %h",
                     rdv, exp_status(0, 1, 0));
        end
    endtask

    task automatic test_timeout;
        out_ready = 0; popped.delete(); exp_q.delete();
        fill(DEPTH);
        bus(A_VAL, $urandom, 4'hF, 1200);
        n_chk++;
        if (lat !== 1025 || aft !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_lat got %0d/%b want 1025/0",
                     lat, aft);
        end
        bus(A_STS, 0, 4'h0, 20);
        n_chk++;
        if (rdv !== exp_status(DEPTH, 0, 1)) begin
            n_fail++;
            $display("FAIL overflow_set got %h want %h",
                     rdv, exp_status(DEPTH, 0, 1));
        end
        bus(A_STS, 0, 4'h0, 20);
        n_chk++;
        if (rdv !== exp_status(DEPTH, 0, 0)) begin
            n_fail++;
            $display("FAIL overflow_clr got %h want %h",
                     rdv, exp_status(DEPTH, 0, 0));
        end
        bus(A_CTL, 32'h2, 4'h1, 20);
        exp_q.delete();
        bus(A_STS, 0, 4'h0, 20);
        n_chk++;
        if (rdv !== exp_status(0, 0, 0) || popped.size() !== 0) begin
            n_fail++;
            $display("FAIL flush_full got %h/%0d want %h/0",
                     rdv, popped.size(), exp_status(0, 0, 0));
        end
    endtask

    task automatic test_irq_flush;
        pop_t        p;
        logic [39:0] e;
        int          nm;
        bus(A_CTL, 32'h1, 4'h1, 20);
        out_ready = 0; popped.delete(); exp_q.delete();
        fill(3);
        n_chk++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_early got %b want 0", irq);
        end
        out_ready = 1;
        repeat (6) @(posedge clk_50M); #1;
        out_ready = 0;
        n_chk++;
        if (popped.size() !== 3 || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_drain got %0d/%b want 3/1",
                     popped.size(), irq);
        end
        nm = 0;
        while (popped.size() > 0 && exp_q.size() > 0) begin
            p = popped.pop_front(); e = exp_q.pop_front();
            if ({p.id, p.val} !== e) nm++;
        end
        n_chk++;
        if (nm !== 0) begin
            n_fail++; $display("FAIL irq_order got %0d bad want 0", nm);
        end
        bus(A_STS, 0, 4'h0, 20);
        n_chk++;
        if (rdv !== exp_status(0, 1, 0) || irr !== 1'b1
            || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_clear got %h/%b/%b want %h/1/0",
                     rdv, irr, irq, exp_status(0, 1, 0));
        end
        fill(5);
        bus(A_STS, 0, 4'h0, 20);
        n_chk++;
        if (rdv !== exp_status(5, 0, 0)) begin
            n_fail++;
            $display("FAIL pre_flush got %h want %h",
                     rdv, exp_status(5, 0, 0));
        end
        bus(A_CTL, 32'h3, 4'h1, 20);
        exp_q.delete();
        bus(A_STS, 0, 4'h0, 20);
        n_chk++;
        if (rdv !== exp_status(0, 0, 0) || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL flush got %h/%b want %h/0",
                     rdv, irq, exp_status(0, 0, 0));
        end
        bus(A_CTL, 0, 4'h0, 20);
        n_chk++;
        if (rdv !== 32'h1) begin
            n_fail++; $display("FAIL ctrl_read got %h want 1", rdv);
        end
        bus(A_CTL, 32'h0, 4'h1, 20);
    endtask

    task automatic test_rst_stall;
        out_ready = 0; popped.delete(); exp_q.delete();
        fill(DEPTH);
        fork
            bus(A_VAL, $urandom, 4'hF, 60);
            begin
                repeat (30) @(negedge clk_50M);
                rst = 1; #1;
                n_chk++;
                if (out_valid !== 1'b0 || mem_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rst_mid got %b%b want 00",
                             out_valid, mem_ready);
                end
                repeat (60) @(negedge clk_50M);
                rst = 0;
            end
        join
        exp_q.delete(); model_id = 8'h00;
        n_chk++;
        if (lat !== -1) begin
            n_fail++; $display("FAIL rst_noready got %0d want -1", lat);
        end
        bus(A_STS, 0, 4'h0, 20);
        n_chk++;
        if (rdv !== 32'h0000_0002) begin
            n_fail++;
            $display("FAIL rst_status2 got %h want 00000002", rdv);
        end
    endtask

    task automatic test_window;
        @(negedge clk_50M);
        mem_valid = 1; mem_wstrb = 0; mem_addr = BASE + 32'h10; #1;
        n_chk++;
        if (sel !== 1'b0) begin
            n_fail++; $display("FAIL sel_above got %b want 0", sel);
        end
        mem_addr = BASE + 32'hC; #1;
        n_chk++;
        if (sel !== 1'b1) begin
            n_fail++; $display("FAIL sel_inside got %b want 1", sel);
        end
        mem_addr = BASE - 32'h4; #1;
        n_chk++;
        if (sel !== 1'b0) begin
            n_fail++; $display("FAIL sel_below got %b want 0", sel);
        end
        mem_valid = 0;
        bus(BASE + 32'h10, 0, 4'h0, 20);
        n_chk++;
        if (lat !== -1) begin
            n_fail++; $display("FAIL oow_read got %0d want -1", lat);
        end
        bus(BASE + 32'h10, 32'h77, 4'hF, 20);
        bus(A_ID, 0, 4'h0, 20);
        n_chk++;
        if (rdv !== {24'h0, model_id}) begin
            n_fail++;
            $display("FAIL oow_nochange got %h want %h",
                     rdv, {24'h0, model_id});
        end
        out_ready = 1; popped.delete();
        bus(A_VAL, $urandom, 4'b0011, 20);
        repeat (3) @(posedge clk_50M); #1;
        out_ready = 0;
        n_chk++;
        if (lat !== 1 || popped.size() !== 0) begin
            n_fail++;
            $display("FAIL partial_wr got %0d/%0d want 1/0",
                     lat, popped.size());
        end
        bus(A_STS, 0, 4'h0, 20);
        n_chk++;
        if (rdv !== exp_status(0, 0, 0)) begin
            n_fail++;
            $display("FAIL partial_count got %h want %h",
                     rdv, exp_status(0, 0, 0));
        end
    endtask

    task automatic test_random;
        pop_t        p;
        logic [39:0] e;
        logic [31:0] v;
        int          op;
        out_ready = 0; popped.delete(); exp_q.delete();
        for (int it = 0; it < 160; it++) begin
            op = $urandom_range(0, 9);
            if (op >= 8) out_ready = 0;
            while (popped.size() > 0) begin
                p = popped.pop_front();
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                n_chk++;
                if ({p.id, p.val} !== e) begin
                    n_fail++;
                    $display("FAIL rnd_pop[%0d] got %h want %h",
                             it, {p.id, p.val}, e);
                end
            end
            if (op <= 4) begin
                if (exp_q.size() >= DEPTH) out_ready = 1;
                v = $urandom;
                bus(A_VAL, v, 4'hF, 100);
                exp_q.push_back({model_id, v});
                n_chk++;
                if (lat < 1) begin
                    n_fail++;
                    $display("FAIL rnd_push[%0d] got %0d want >0",
                             it, lat);
                end
            end else if (op == 5) begin
                model_id = 8'($urandom);
                bus(A_ID, {24'h0, model_id}, 4'h1, 20);
            end else if (op <= 7) begin
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                bus(A_STS, 0, 4'h0, 20);
                n_chk++;
                if ((rdv & ~32'h8) !== exp_status(exp_q.size(), 0, 0))
                begin
                    n_fail++;
                    $display("FAIL rnd_status[%0d] got %h want %h",
                             it, rdv & ~32'h8,
                             exp_status(exp_q.size(), 0, 0));
                end
            end
        end
        out_ready = 1;
        repeat (DEPTH + 4) @(posedge clk_50M); #1;
        out_ready = 0;
        while (popped.size() > 0) begin
            p = popped.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_chk++;
            if ({p.id, p.val} !== e) begin
                n_fail++;
                $display("FAIL rnd_tail got %h want %h",
                         {p.id, p.val}, e);
            end
        end
        n_chk++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL rnd_left got %0d want 0", exp_q.size());
        end
        bus(A_STS, 0, 4'h0, 20);
        n_chk++;
        if ((rdv & ~32'h8) !== 32'h2) begin
            n_fail++;
            $display("FAIL rnd_final got %h want 2", rdv & ~32'h8);
        end
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        mem_valid = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0;
        out_ready = 0; rst = 1; model_id = 8'h00;
        test_reset();
        test_basic();
        test_back_to_back();
        test_timeout();
        test_irq_flush();
        test_rst_stall();
        test_window();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
